// File: rtl/scan_chain_ctrl_if.sv
// rtl/scan_chain_ctrl_if.sv - pattern request/response bus and scan-chain pins of scan_chain_ctrl
// SIG is present only when SCAN_CTRL_MISR_EN is defined.
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 32
);
  logic                 START;
  logic [CHAIN_LEN-1:0] PAT_IN;
  logic [CHAIN_LEN-1:0] EXP_IN;
  logic                 SO;
  logic                 SE;
  logic                 SI;
  logic                 BUSY;
  logic                 DONE;
  logic                 FAIL;
  logic [CHAIN_LEN-1:0] RESP;
`ifdef SCAN_CTRL_MISR_EN
  logic [15:0]          SIG;

  modport slave  (input  START, PAT_IN, EXP_IN, SO,
                  output SE, SI, BUSY, DONE, FAIL, RESP, SIG);
  modport master (output START, PAT_IN, EXP_IN, SO,
                  input  SE, SI, BUSY, DONE, FAIL, RESP, SIG);
`else
  modport slave  (input  START, PAT_IN, EXP_IN, SO,
                  output SE, SI, BUSY, DONE, FAIL, RESP);
  modport master (output START, PAT_IN, EXP_IN, SO,
                  input  SE, SI, BUSY, DONE, FAIL, RESP);
`endif
endinterface

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan chain load / capture / unload / compare controller
// Optional serial CRC-16 signature of unloaded bits: define SCAN_CTRL_MISR_EN.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 6
) (
  input  logic              CLK,
  input  logic              RSTB,
  scan_chain_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_CMP     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 fail_q, fail_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic [CHAIN_LEN-1:0] load_src;
  logic [CNT_W-1:0]     load_idx;
`ifdef SCAN_CTRL_MISR_EN
  logic [15:0]          sig_q, sig_d;
`endif

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      exp_q   <= '0;
      resp_q  <= '0;
      fail_q  <= 1'b0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCAN_CTRL_MISR_EN
      sig_q   <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      resp_q  <= resp_d;
      fail_q  <= fail_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SCAN_CTRL_MISR_EN
      sig_q   <= sig_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    exp_d   = exp_q;
    resp_d  = resp_q;
    fail_d  = fail_q;
    accept  = 1'b0;
`ifdef SCAN_CTRL_MISR_EN
    sig_d   = sig_q;
`endif
    case (state_q)
      S_IDLE, S_CMP: begin
        accept  = bus.START;
        state_d = bus.START ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_UNLOAD;
        cnt_d   = '0;
      end
      S_UNLOAD: begin
        // SO is sampled before this edge shifts the chain, so bit k lands MSB-first.
        for (int i = 0; i < CHAIN_LEN; i++) begin
          if (cnt_q == CNT_W'(CHAIN_LEN - 1 - i)) resp_d[i] = bus.SO;
        end
`ifdef SCAN_CTRL_MISR_EN
        sig_d = {sig_q[14:0], 1'b0} ^ ({16{sig_q[15] ^ bus.SO}} & 16'h1021);
`endif
        if (cnt_q == CNT_LAST) begin
          state_d = S_CMP;
          cnt_d   = '0;
          fail_d  = (resp_d != exp_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      pat_d  = bus.PAT_IN;
      exp_d  = bus.EXP_IN;
      fail_d = 1'b0;
      cnt_d  = '0;
    end
  end

  // Outputs are decoded from the next state so SE/SI/BUSY/DONE come straight from flops.
  always_comb begin
    se_d     = 1'b0;
    si_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load_src = accept ? bus.PAT_IN : pat_q;
    load_idx = accept ? CNT_LAST : (CNT_LAST - 1'b1 - cnt_q);
    case (state_d)
      S_LOAD: begin
        se_d   = 1'b1;
        busy_d = 1'b1;
        for (int i = 0; i < CHAIN_LEN; i++) begin
          if (load_idx == CNT_W'(i)) si_d = load_src[i];
        end
      end
      S_CAPTURE: busy_d = 1'b1;
      S_UNLOAD: begin
        se_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_CMP:   done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.SE   = se_q;
  assign bus.SI   = si_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.FAIL = fail_q;
  assign bus.RESP = resp_q;
`ifdef SCAN_CTRL_MISR_EN
  assign bus.SIG  = sig_q;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - directed bench for scan_chain_ctrl with a behavioural inverting 32-cell chain
module tb_scan_chain_ctrl;
  localparam int N = 32;

  logic CLK  = 1'b0;
  logic RSTB = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [N-1:0] chain = '0;

  scan_chain_ctrl_if #(.CHAIN_LEN(N)) bus();

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(6)) dut (
    .CLK  (CLK),
    .RSTB (RSTB),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Scan cells: shift from SI toward SO when SE=1, otherwise capture inverted value.
  always @(posedge CLK) begin
    if (bus.SE) chain <= {chain[N-2:0], bus.SI};
    else        chain <= ~chain;
  end
  assign bus.SO = chain[N-1];

  task automatic run_pattern(input logic [N-1:0] pat, input logic [N-1:0] expw,
                             input logic [N-1:0] resp_exp, input logic fail_exp,
                             input bit started, input bit poke, input bit chain_next,
                             input logic [N-1:0] pat2, input logic [N-1:0] exp2);
    logic [3:0] ctl_exp;
    logic [3:0] ctl_got;
    if (!started) begin
      @(negedge CLK);
      bus.START  = 1'b1;
      bus.PAT_IN = pat;
      bus.EXP_IN = expw;
    end
    for (int c = 1; c <= 2*N+2; c++) begin
      @(negedge CLK);
      if (c == 1 || c == 6 || c == 41) bus.START = 1'b0;
      if (poke && (c == 5 || c == 40)) begin
        bus.START  = 1'b1;
        bus.PAT_IN = ~pat;
        bus.EXP_IN = 32'h1234_5678;
      end
      ctl_exp[3] = (c <= N) || (c >= N+2 && c <= 2*N+1);
      ctl_exp[2] = (c <= N) ? pat[N-c] : 1'b0;
      ctl_exp[1] = (c <= 2*N+1);
      ctl_exp[0] = (c == 2*N+2);
      ctl_got    = {bus.SE, bus.SI, bus.BUSY, bus.DONE};
      n_cmp++;
      if (ctl_got !== ctl_exp) begin
        n_bad++;
        $display("FAIL seq_ctl cycle %0d: {SE,SI,BUSY,DONE} got %b want %b", c, ctl_got, ctl_exp);
      end
      if (c == 1) begin
        n_cmp++;
        if (bus.FAIL !== 1'b0) begin
          n_bad++;
          $display("FAIL fail_clear cycle 1: got %b want 0", bus.FAIL);
        end
      end
      if (c == 2*N+2) begin
        n_cmp++;
        if (bus.RESP !== resp_exp) begin
          n_bad++;
          $display("FAIL resp: got %h want %h", bus.RESP, resp_exp);
        end
        n_cmp++;
        if (bus.FAIL !== fail_exp) begin
          n_bad++;
          $display("FAIL fail_flag: got %b want %b", bus.FAIL, fail_exp);
        end
        if (chain_next) begin
          bus.START  = 1'b1;
          bus.PAT_IN = pat2;
          bus.EXP_IN = exp2;
        end
      end
    end
  endtask

  task automatic test_reset();
    RSTB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      bus.START  = i[0];
      bus.PAT_IN = 32'hFFFF_FFFF;
      bus.EXP_IN = 32'h0;
      n_cmp++;
      if ({bus.SE, bus.SI, bus.BUSY, bus.DONE, bus.FAIL} !== 5'b0 || bus.RESP !== '0) begin
        n_bad++;
        $display("FAIL reset_state: ctl %b resp %h want 0",
                 {bus.SE, bus.SI, bus.BUSY, bus.DONE, bus.FAIL}, bus.RESP);
      end
    end
    @(negedge CLK);
    bus.START = 1'b0;
    RSTB      = 1'b1;
  endtask

  task automatic test_pass();
    run_pattern(32'hA5A5_0F0F, 32'h5A5A_F0F0, 32'h5A5A_F0F0, 1'b0, 0, 0, 0, '0, '0);
  endtask

  task automatic test_fail();
    run_pattern(32'hA5A5_0F0F, 32'h5A5A_F0F1, 32'h5A5A_F0F0, 1'b1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (bus.FAIL !== 1'b1 || bus.DONE !== 1'b0 || bus.RESP !== 32'h5A5A_F0F0) begin
        n_bad++;
        $display("FAIL fail_hold: FAIL %b DONE %b RESP %h want 1 0 5a5af0f0",
                 bus.FAIL, bus.DONE, bus.RESP);
      end
    end
    run_pattern(32'hA5A5_0F0F, 32'h5A5A_F0F0, 32'h5A5A_F0F0, 1'b0, 0, 0, 0, '0, '0);
  endtask

  task automatic test_ignore_start();
    run_pattern(32'h0123_4567, 32'hFEDC_BA98, 32'hFEDC_BA98, 1'b0, 0, 1, 0, '0, '0);
  endtask

  task automatic test_back_to_back();
    run_pattern(32'hA5A5_0F0F, 32'h5A5A_F0F0, 32'h5A5A_F0F0, 1'b0, 0, 0, 1,
                32'h0000_FFFF, 32'hFFFF_0000);
    run_pattern(32'h0000_FFFF, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0, 1, 0, 0, '0, '0);
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    bus.START  = 1'b1;
    bus.PAT_IN = 32'hA5A5_0F0F;
    bus.EXP_IN = 32'h5A5A_F0F0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (c == 1) bus.START = 1'b0;
    end
    n_cmp++;
    if (bus.SE !== 1'b1 || bus.BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_load: SE %b BUSY %b want 1 1", bus.SE, bus.BUSY);
    end
    RSTB = 1'b0;
    #1;
    n_cmp++;
    if ({bus.SE, bus.SI, bus.BUSY, bus.DONE, bus.FAIL} !== 5'b0 || bus.RESP !== '0) begin
      n_bad++;
      $display("FAIL async_abort: ctl %b resp %h want 0",
               {bus.SE, bus.SI, bus.BUSY, bus.DONE, bus.FAIL}, bus.RESP);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (bus.SE !== 1'b0 || bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_hold: SE %b DONE %b BUSY %b want 0", bus.SE, bus.DONE, bus.BUSY);
      end
    end
    RSTB = 1'b1;
    run_pattern(32'hA5A5_0F0F, 32'h5A5A_F0F0, 32'h5A5A_F0F0, 1'b0, 0, 0, 0, '0, '0);
  endtask

`ifdef SCAN_CTRL_MISR_EN
  task automatic test_misr();
    logic [15:0] s;
    logic [N-1:0] r;
    @(negedge CLK);
    RSTB = 1'b0;
    @(negedge CLK);
    RSTB = 1'b1;
    n_cmp++;
    if (bus.SIG !== 16'h0000) begin
      n_bad++;
      $display("FAIL sig_reset: got %h want 0000", bus.SIG);
    end
    run_pattern(32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 0, 0, 0, '0, '0);
    n_cmp++;
    if (bus.SIG !== 16'h0000) begin
      n_bad++;
      $display("FAIL sig_zero: got %h want 0000", bus.SIG);
    end
    @(negedge CLK);
    RSTB = 1'b0;
    @(negedge CLK);
    RSTB = 1'b1;
    run_pattern(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0, 0, '0, '0);
    s = 16'h0000;
    r = 32'h8000_0000;
    for (int i = N-1; i >= 0; i--) s = {s[14:0], 1'b0} ^ ({16{s[15] ^ r[i]}} & 16'h1021);
    n_cmp++;
    if (bus.SIG !== s) begin
      n_bad++;
      $display("FAIL sig_msb: got %h want %h", bus.SIG, s);
    end
  endtask
`endif

  initial begin
    bus.START  = 1'b0;
    bus.PAT_IN = '0;
    bus.EXP_IN = '0;
    test_reset();
    test_pass();
    test_fail();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SCAN_CTRL_MISR_EN
    test_misr();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequential scan-test controller that sits directly upstream and downstream of a chain of scan flip-flops with asynchronous set/reset. It drives the chain's shared scan-enable and the first cell's scan-in, and reads the last cell's scan-out. For each pattern it serially loads a stimulus word, issues one functional capture clock, unloads the captured response, and compares it against an expected word.

## Interface
Parameters:
- CHAIN_LEN, 32: number of scan cells in the chain; ≥2.
- CNT_W, 6: shift counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- CLK  input  1  clock; all state on rising edge; same clock as the chain.
- RSTB  input  1  reset, asynchronous, active-low.
- START  input  1  request one pattern; sampled only when BUSY=0.
- PAT_IN  input  CHAIN_LEN  stimulus; latched on accepted START.
- EXP_IN  input  CHAIN_LEN  expected response; latched on accepted START.
- SO  input  1  scan-out of last chain cell (its S0/Q).
- SE  output  1  scan enable to every chain cell.
- SI  output  1  scan-in to first chain cell.
- BUSY  output  1  high during LOAD, CAPTURE, UNLOAD.
- DONE  output  1  one-cycle pulse; RESP/FAIL valid.
- FAIL  output  1  RESP != latched EXP; held until next accepted START.
- RESP  output  CHAIN_LEN  unloaded response; held until next unload.

## Operation
- Cell 0 is fed by SI; cell CHAIN_LEN-1 drives SO.
- States: IDLE, LOAD, CAPTURE, UNLOAD, CMP.
- IDLE: SE=0, SI=0. START=1 → latch PAT_IN/EXP_IN, clear FAIL, counter=0, go LOAD.
- LOAD: SE=1. Shift cycle k (0..CHAIN_LEN-1) drives SI=PAT[CHAIN_LEN-1-k]. After CHAIN_LEN cycles cell i holds PAT[i]. Go CAPTURE.
- CAPTURE: exactly one cycle, SE=0, SI=0; the chain takes its functional D. Go UNLOAD, counter=0.
- UNLOAD: SE=1, SI=0. At the rising edge ending unload cycle k, sample SO into RESP[CHAIN_LEN-1-k]. After CHAIN_LEN cycles go CMP.
- CMP: one cycle. DONE=1, FAIL=(RESP!=EXP), BUSY=0. START=1 here is accepted (back-to-back) → LOAD; otherwise → IDLE.
- START while BUSY=1: ignored, with no effect on the latched words.
- Counter wraps to 0 on every LOAD→CAPTURE and UNLOAD→CMP transition. It never exceeds CHAIN_LEN-1.
- SE and SI are registered outputs with no combinational path from inputs.

## Timing
- Reset (RSTB=0, takes effect immediately): state=IDLE, SE=0, SI=0, BUSY=0, DONE=0, FAIL=0, RESP=0, counter=0, latched PAT/EXP=0.
- Reset mid-pattern: abort immediately. SE drops to 0 with no further shifts, and all outputs return to their reset values. After RSTB rises, the first START is accepted normally.
- START high in cycle 0 (BUSY=0):
  - Cycles 1..N (N=CHAIN_LEN) are LOAD.
  - Cycle N+1 is CAPTURE.
  - Cycles N+2..2N+1 are UNLOAD.
  - Cycle 2N+2 is CMP with DONE=1.
- Pattern latency START→DONE = 2N+2 cycles. Back-to-back period = 2N+2 cycles.
- BUSY=1 in cycles 1..2N+1.
- FAIL and RESP update at the edge entering CMP and are stable during DONE.

## Configuration
- SCAN_CTRL_MISR_EN defined:
  - Adds output SIG[15:0], reset to 16'h0000.
  - On each UNLOAD sample edge: SIG <= {SIG[14:0],1'b0} ^ ({16{SIG[15]^SO}} & 16'h1021). This is a serial CRC-16-CCITT accumulated across all patterns.
  - SIG is cleared only by RSTB.
- Not defined: port SIG and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold RSTB=0 with START toggling → SE=0, SI=0, BUSY=0, DONE=0, FAIL=0, RESP=0.
- CHAIN_LEN=32 with a behavioural 32-cell chain, capture D = cell value inverted. PAT_IN=32'hA5A5_0F0F, EXP_IN=32'h5A5A_F0F0 → SI serial sequence MSB first, SE low only in cycle 33, DONE in cycle 66, RESP=32'h5A5A_F0F0, FAIL=0.
- Same pattern with EXP_IN=32'h5A5A_F0F1 → DONE in cycle 66, FAIL=1. FAIL stays high until the next START and is then cleared in cycle 1.
- START re-asserted during cycles 5 and 40 → ignored, DONE still in cycle 66. START held high in cycle 66 → next LOAD in cycle 67, next DONE in cycle 132.
- RSTB pulsed low in cycle 20 (LOAD) → SE=0 and BUSY=0 immediately, no DONE. The next START runs a full 66-cycle pattern correctly.
- SCAN_CTRL_MISR_EN, all-zero response → SIG=16'h0000. A single response with only cell 31 set (first bit out) → SIG matches the model-computed CRC.
